// File: rtl/iterative_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divider_pkg
//  Description : Shared types for the iterative divider: FSM state encoding
//                and its width.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/iterative_divider_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational radix-2 restoring division step.
//  Ports       : rem_i     - partial remainder entering the step (< divisor)
//                bit_i     - next dividend bit shifted in at the LSB
//                divisor_i - divisor (non-zero)
//                rem_o     - partial remainder leaving the step
//                q_bit_o   - quotient bit produced by this step
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    // The shifted value keeps the remainder MSB as an extra bit. With a
    // divisor above 2^(WIDTH-1) the remainder can have its MSB set, and
    // dropping it would corrupt the trial subtraction.
    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {rem_i, bit_i};
        // No borrow when the shifted value overflows WIDTH bits or is
        // already >= divisor.
        q_bit_o = shifted[WIDTH] || (shifted[WIDTH-1:0] >= divisor_i);
        // On no-borrow the true difference is < divisor, so the WIDTH-bit
        // modular subtraction yields it exactly.
        rem_o   = q_bit_o ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/iterative_divider.sv
`default_nettype none
// ============================================================================
//  Module      : iterative_divider
//  Description : Unsigned radix-2 restoring divider, one quotient bit per
//                cycle, one operation in flight, ready/valid handshakes.
//  Ports       : clock, reset          - clock, synchronous active-high reset
//                in_valid / in_ready   - operand handshake
//                dividend, divisor     - unsigned operands
//                out_valid / out_ready - result handshake
//                quotient, remainder   - unsigned results
//                div_by_zero           - result came from a zero divisor
//  Revision    : 1.0 - initial release
// ============================================================================
module iterative_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    div_state_t       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] rem_q,     rem_d;
    logic [WIDTH-1:0] quo_q,     quo_d;
    logic             dbz_q,     dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    // The quotient register doubles as the dividend shift register: its MSB
    // feeds the step, and quotient bits fill in from the LSB.
    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (quo_q[WIDTH-1]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    assign in_ready    = (state_q == ST_IDLE) && !reset;
    assign out_valid   = (state_q == ST_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dbz_d     = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    if (divisor != '0) begin
                        divisor_d = divisor;
                        rem_d     = '0;
                        quo_d     = dividend;
                        cnt_d     = '0;
                        dbz_d     = 1'b0;
                        state_d   = ST_BUSY;
                    end else begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q + CNT_ONE;
                dbz_d = 1'b0;
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dbz_q     <= dbz_d;
        end
    end

endmodule
`default_nettype wire
